display_sequencer: RTL and testbench

DISPLAY_SEQUENCER -- requirements
Module: display_sequencer

---
 rtl/display_sequencer.sv | 153 +++++++++++++++
 tb/tb_display_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/display_sequencer.sv
// Three-digit decimal display sequencer: an 8-bit load is converted to BCD by
// iterative double-dabble, committed atomically, then multiplexed onto a 7-seg.

// One BCD nibble of the double-dabble adjust: add 3 when the digit exceeds 4.
module display_sequencer_dabble (
  input  logic [3:0] nib,
  output logic [3:0] adj
);
  assign adj = (nib > 4'd4) ? 4'(nib + 4'd3) : nib;
endmodule

module display_sequencer #(
  parameter int unsigned SCAN_DIV = 1000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [7:0] bus,
  input  logic       input_en,
  output logic       busy,
  output logic [6:0] display,
  output logic [2:0] display_en
);

  localparam int unsigned NUM_DIGITS = 3;
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CONVERT = 2'd1;
  localparam logic [1:0] COMMIT  = 2'd2;

  logic [1:0]  state;
  logic [2:0]  step;
  logic [19:0] sreg;
  logic [19:0] sreg_adj;
  logic [19:0] sreg_step;
  logic [7:0]  pend;
  logic        pend_valid;
  logic [NUM_DIGITS-1:0][3:0] digits;   // [0]=ones [1]=tens [2]=hundreds
  logic [15:0] presc;
  logic [1:0]  idx;

  assign busy = (state != IDLE);

  // BCD nibbles sit above the 8 binary bits; the binary part shifts through untouched.
  assign sreg_adj[7:0] = sreg[7:0];
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dabble
    display_sequencer_dabble u_dabble (
      .nib (sreg[8+4*g +: 4]),
      .adj (sreg_adj[8+4*g +: 4])
    );
  end
  assign sreg_step = sreg_adj << 1;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state      <= IDLE;
      step       <= 3'd0;
      sreg       <= 20'd0;
      pend       <= 8'd0;
      pend_valid <= 1'b0;
      digits     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (input_en) begin
            sreg  <= {12'd0, bus};
            step  <= 3'd0;
            state <= CONVERT;
          end
        end
        CONVERT: begin
          sreg <= sreg_step;
          step <= step + 3'd1;
          if (step == 3'd7) state <= COMMIT;
          if (input_en) begin
            pend       <= bus;
            pend_valid <= 1'b1;
          end
        end
        COMMIT: begin
          for (int i = 0; i < NUM_DIGITS; i++) digits[i] <= sreg[8+4*i +: 4];
          // A fresh request on the commit edge beats any queued one.
          if (input_en) begin
            sreg       <= {12'd0, bus};
            step       <= 3'd0;
            pend_valid <= 1'b0;
            state      <= CONVERT;
          end else if (pend_valid) begin
            sreg       <= {12'd0, pend};
            step       <= 3'd0;
            pend_valid <= 1'b0;
            state      <= CONVERT;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Digit scan runs independently of the converter.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      presc <= 16'd0;
      idx   <= 2'd0;
    end else if (presc == 16'(SCAN_DIV - 1)) begin
      presc <= 16'd0;
      idx   <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end else begin
      presc <= presc + 16'd1;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1111110;
      4'd1:    seg7 = 7'b0110000;
      4'd2:    seg7 = 7'b1101101;
      4'd3:    seg7 = 7'b1111001;
      4'd4:    seg7 = 7'b0110011;
      4'd5:    seg7 = 7'b1011011;
      4'd6:    seg7 = 7'b1011111;
      4'd7:    seg7 = 7'b1110000;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1111011;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

  logic [3:0] cur_digit;
  logic       blank;

  always_comb begin
    cur_digit  = digits[0];
    blank      = 1'b0;
    display_en = 3'b110;
    case (idx)
      2'd1: begin
        cur_digit  = digits[1];
        blank      = BLANK_LZ && (digits[2] == 4'd0) && (digits[1] == 4'd0);
        display_en = 3'b101;
      end
      2'd2: begin
        cur_digit  = digits[2];
        blank      = BLANK_LZ && (digits[2] == 4'd0);
        display_en = 3'b011;
      end
      default: ;
    endcase
    display = blank ? 7'b0000000 : seg7(cur_digit);
  end

endmodule

// File: tb/tb_display_sequencer.sv
// Bench for display_sequencer: table vectors, corner sequences and random
// traffic, all checked against a countdown/arithmetic reference model.
module tb_display_sequencer;

  logic       clk, clear, input_en;
  logic [7:0] bus;
  logic       busy1, busy2, busy3;
  logic [6:0] disp1, disp2, disp3;
  logic [2:0] den1, den2, den3;

  display_sequencer #(.SCAN_DIV(1), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .clear(clear), .bus(bus), .input_en(input_en),
    .busy(busy1), .display(disp1), .display_en(den1));
  display_sequencer #(.SCAN_DIV(1), .BLANK_LZ(1'b0)) dut_nb (
    .clk(clk), .clear(clear), .bus(bus), .input_en(input_en),
    .busy(busy2), .display(disp2), .display_en(den2));
  display_sequencer #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut_s4 (
    .clk(clk), .clear(clear), .bus(bus), .input_en(input_en),
    .busy(busy3), .display(disp3), .display_en(den3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a busy countdown plus the value each phase holds.
  int m_rem, m_job, m_pend, m_shown, m_edges;
  bit m_pv;

  typedef struct {
    logic [7:0] val;
    logic [6:0] o, t, h, t_nb, h_nb;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: seg = 7'b1111110;  1: seg = 7'b0110000;
      2: seg = 7'b1101101;  3: seg = 7'b1111001;
      4: seg = 7'b0110011;  5: seg = 7'b1011011;
      6: seg = 7'b1011111;  7: seg = 7'b1110000;
      8: seg = 7'b1111111;  9: seg = 7'b1111011;
      default: seg = 7'b0000000;
    endcase
  endfunction

  function automatic logic [6:0] exp_disp(input int v, input int ix, input bit blz);
    int h, t, o;
    h = v / 100; t = (v / 10) % 10; o = v % 10;
    if (ix == 0) exp_disp = seg(o);
    else if (ix == 1) exp_disp = (blz && h == 0 && t == 0) ? 7'd0 : seg(t);
    else exp_disp = (blz && h == 0) ? 7'd0 : seg(h);
  endfunction

  function automatic logic [2:0] exp_en(input int ix);
    exp_en = (ix == 0) ? 3'b110 : (ix == 1) ? 3'b101 : 3'b011;
  endfunction

  task automatic model_edge();
    if (m_rem == 0) begin
      if (input_en) begin m_job = bus; m_rem = 9; end
    end else if (m_rem == 1) begin
      m_shown = m_job;
      if (input_en) begin m_job = bus; m_rem = 9; m_pv = 0; end
      else if (m_pv) begin m_job = m_pend; m_rem = 9; m_pv = 0; end
      else m_rem = 0;
    end else begin
      if (input_en) begin m_pend = bus; m_pv = 1; end
      m_rem--;
    end
    m_edges++;
  endtask

  task automatic tick();
    int i1, i4;
    @(posedge clk);
    model_edge();
    #1;
    i1 = m_edges % 3;
    i4 = (m_edges / 4) % 3;
    chk("busy", busy1, m_rem != 0);
    chk("busy_nb", busy2, m_rem != 0);
    chk("busy_s4", busy3, m_rem != 0);
    chk("display", disp1, exp_disp(m_shown, i1, 1'b1));
    chk("display_nb", disp2, exp_disp(m_shown, i1, 1'b0));
    chk("display_s4", disp3, exp_disp(m_shown, i4, 1'b1));
    chk("display_en", den1, exp_en(i1));
    chk("display_en_s4", den3, exp_en(i4));
  endtask

  task automatic do_clear();
    clear = 1'b1;
    input_en = 1'b0;
    #1;
    chk("rst busy", {busy1, busy2, busy3}, 3'b000);
    chk("rst display_en", {den1, den2, den3}, {3'b110, 3'b110, 3'b110});
    chk("rst display", {disp1, disp2, disp3}, {7'b1111110, 7'b1111110, 7'b1111110});
    m_rem = 0; m_pv = 0; m_shown = 0; m_edges = 0; m_job = 0; m_pend = 0;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic check_slots(input string name, input vec_t v);
    int ix;
    repeat (3) begin
      tick();
      ix = m_edges % 3;
      chk({name, " blz"}, disp1, (ix == 0) ? v.o : (ix == 1) ? v.t : v.h);
      chk({name, " noblz"}, disp2, (ix == 0) ? v.o : (ix == 1) ? v.t_nb : v.h_nb);
    end
  endtask

  task automatic load(input logic [7:0] v);
    bus = v; input_en = 1'b1;
    tick();
    input_en = 1'b0;
  endtask

  initial begin
    int busy_cnt;
    vec_t v;
    clear = 1'b0; input_en = 1'b0; bus = 8'd0;
    vecs[0] = '{8'd255, 7'h5B, 7'h5B, 7'h6D, 7'h5B, 7'h6D};
    vecs[1] = '{8'd7,   7'h70, 7'h00, 7'h00, 7'h7E, 7'h7E};
    vecs[2] = '{8'd200, 7'h7E, 7'h7E, 7'h6D, 7'h7E, 7'h6D};
    vecs[3] = '{8'd0,   7'h7E, 7'h00, 7'h00, 7'h7E, 7'h7E};
    vecs[4] = '{8'd105, 7'h5B, 7'h7E, 7'h30, 7'h7E, 7'h30};
    vecs[5] = '{8'd42,  7'h6D, 7'h33, 7'h00, 7'h33, 7'h7E};
    vecs[6] = '{8'd90,  7'h7E, 7'h7B, 7'h00, 7'h7B, 7'h7E};
    #2;
    do_clear();
    repeat (7) tick();

    // Single loads: busy for exactly 9 edges, then the committed digits.
    for (int i = 0; i < 7; i++) begin
      load(vecs[i].val);
      busy_cnt = 1;
      for (int c = 1; c <= 10; c++) begin
        tick();
        busy_cnt += int'(busy1);
      end
      chk("load busy cycles", busy_cnt, 9);
      check_slots("vec", vecs[i]);
    end

    // Queueing: 42 is overwritten by 9 before service; busy never drops.
    load(8'd100);
    busy_cnt = 1;
    for (int c = 1; c <= 22; c++) begin
      input_en = (c == 3 || c == 5);
      bus = (c == 3) ? 8'd42 : 8'd9;
      tick();
      busy_cnt += int'(busy1);
    end
    input_en = 1'b0;
    chk("queue busy cycles", busy_cnt, 18);
    v = '{8'd9, 7'h7B, 7'h00, 7'h00, 7'h7E, 7'h7E};
    check_slots("queue", v);

    // Collision on the commit edge: the live request wins, pending is dropped.
    load(8'd50);
    for (int c = 1; c <= 18; c++) begin
      input_en = (c == 2 || c == 9);
      bus = (c == 2) ? 8'd42 : 8'd8;
      tick();
    end
    input_en = 1'b0;
    chk("collision idle", busy1, 1'b0);
    v = '{8'd8, 7'h7F, 7'h00, 7'h00, 7'h7E, 7'h7E};
    check_slots("collision", v);

    // Abort mid-conversion, then reload.
    do_clear();
    load(8'd200);
    bus = 8'd33; input_en = 1'b1;
    repeat (3) tick();
    input_en = 1'b0;
    do_clear();
    repeat (12) tick();
    chk("abort idle", busy1, 1'b0);
    v = '{8'd0, 7'h7E, 7'h00, 7'h00, 7'h7E, 7'h7E};
    check_slots("abort", v);
    load(8'd200);
    repeat (9) tick();
    check_slots("reload", vecs[2]);

    // Random traffic with occasional clears.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 249) == 0) do_clear();
      input_en = ($urandom_range(0, 3) == 0);
      bus = 8'($urandom);
      tick();
    end
    input_en = 1'b0;
    repeat (24) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
